// File: rtl/sram_port_arbiter.sv
// Two-port (fetch / LSU) arbiter sequencing 32-bit accesses as two 16-bit SRAM half-accesses.
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration; otherwise data has fixed priority.
module sram_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [3:0]        i_dm_be,
  input  logic [31:0]       i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  output logic [31:0]       o_dm_rdata,
  output logic              o_dm_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_D,
  input  logic [15:0]       SRAM_Q,
  output logic              SRAM_CE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N
);

  localparam int unsigned WA_W  = ADDR_W - 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             gnt_dm, gnt_dm_d;
  logic             lat_we, lat_we_d;
  logic [3:0]       lat_be, lat_be_d;
  logic [31:0]      lat_wdata, lat_wdata_d;
  logic [WA_W-1:0]  lat_waddr, lat_waddr_d;
  logic [31:0]      rbuf, rbuf_d;

  logic [ADDR_W-1:0] sram_addr_d;
  logic [15:0]       sram_d_d;
  logic              ce_n_d, we_n_d, oe_n_d, lb_n_d, ub_n_d;
  logic              if_ack_d, dm_ack_d, busy_d;
  logic [31:0]       if_rdata_d, dm_rdata_d;
  logic              pick_dm, half, phase_done;

`ifdef SRAM_ARB_RR_EN
  logic last_dm, last_dm_d;
`endif

  // Byte-offset bits and bits above the SRAM window carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[31:ADDR_W+1], i_if_addr[1:0],
                              i_dm_addr[31:ADDR_W+1], i_dm_addr[1:0]};

  // Next-state, latched request and next registered output values.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    gnt_dm_d    = gnt_dm;
    lat_we_d    = lat_we;
    lat_be_d    = lat_be;
    lat_wdata_d = lat_wdata;
    lat_waddr_d = lat_waddr;
    rbuf_d      = rbuf;
    sram_addr_d = SRAM_ADDR;
    sram_d_d    = SRAM_D;
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    busy_d      = 1'b0;
    if_rdata_d  = o_if_rdata;
    dm_rdata_d  = o_dm_rdata;
    pick_dm     = 1'b0;
    half        = 1'b0;
    phase_done  = (cnt == CNT_LAST);
`ifdef SRAM_ARB_RR_EN
    last_dm_d   = last_dm;
`endif

    case (state)
      ST_IDLE: begin
        if (i_if_req || i_dm_req) begin
          pick_dm = i_dm_req;
`ifdef SRAM_ARB_RR_EN
          if (i_dm_req && i_if_req) pick_dm = ~last_dm;
          last_dm_d = pick_dm;
`endif
          gnt_dm_d    = pick_dm;
          lat_we_d    = pick_dm & i_dm_we;
          lat_be_d    = i_dm_be;
          lat_wdata_d = i_dm_wdata;
          lat_waddr_d = pick_dm ? i_dm_addr[ADDR_W:2] : i_if_addr[ADDR_W:2];
          cnt_d       = '0;
          if (!(lat_we_d && (lat_be_d[1:0] == 2'b00)))      state_d = ST_LO;
          else if (!(lat_we_d && (lat_be_d[3:2] == 2'b00))) state_d = ST_HI;
          else                                              state_d = ST_ACK;
        end
      end
      ST_LO: begin
        if (phase_done) begin
          if (!lat_we) rbuf_d[15:0] = SRAM_Q;
          cnt_d   = '0;
          state_d = (lat_we && (lat_be[3:2] == 2'b00)) ? ST_ACK : ST_HI;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (phase_done) begin
          if (!lat_we) rbuf_d[31:16] = SRAM_Q;
          cnt_d   = '0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so the pins are valid for its whole duration.
    busy_d = (state_d != ST_IDLE);
    if ((state_d == ST_LO) || (state_d == ST_HI)) begin
      half        = (state_d == ST_HI);
      sram_addr_d = {lat_waddr_d, half};
      ce_n_d      = 1'b0;
      if (lat_we_d) begin
        we_n_d   = 1'b0;
        sram_d_d = half ? lat_wdata_d[31:16] : lat_wdata_d[15:0];
        lb_n_d   = half ? ~lat_be_d[2] : ~lat_be_d[0];
        ub_n_d   = half ? ~lat_be_d[3] : ~lat_be_d[1];
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end

    if (state_d == ST_ACK) begin
      if (gnt_dm_d) begin
        dm_ack_d = 1'b1;
        if (!lat_we_d) dm_rdata_d = rbuf_d;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = rbuf_d;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      gnt_dm     <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      lat_waddr  <= '0;
      rbuf       <= '0;
      SRAM_ADDR  <= '0;
      SRAM_D     <= '0;
      SRAM_CE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      o_if_ack   <= 1'b0;
      o_dm_ack   <= 1'b0;
      o_if_rdata <= '0;
      o_dm_rdata <= '0;
      o_busy     <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_dm    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      gnt_dm     <= gnt_dm_d;
      lat_we     <= lat_we_d;
      lat_be     <= lat_be_d;
      lat_wdata  <= lat_wdata_d;
      lat_waddr  <= lat_waddr_d;
      rbuf       <= rbuf_d;
      SRAM_ADDR  <= sram_addr_d;
      SRAM_D     <= sram_d_d;
      SRAM_CE_N  <= ce_n_d;
      SRAM_WE_N  <= we_n_d;
      SRAM_OE_N  <= oe_n_d;
      SRAM_LB_N  <= lb_n_d;
      SRAM_UB_N  <= ub_n_d;
      o_if_ack   <= if_ack_d;
      o_dm_ack   <= dm_ack_d;
      o_if_rdata <= if_rdata_d;
      o_dm_rdata <= dm_rdata_d;
      o_busy     <= busy_d;
`ifdef SRAM_ARB_RR_EN
      last_dm    <= last_dm_d;
`endif
    end
  end

endmodule
